// File: rtl/regfile_sb16.sv
// 8x16 register file with a busy scoreboard, write-back bypass and RAW stall.
// Read data is registered; stall is combinational against the current scoreboard.
module regfile_sb16 #(
    parameter int WIDTH = 16,
    parameter int AW    = 3,
    parameter int NREG  = 2**AW
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_a_addr,
    input  logic [AW-1:0]    rd_b_addr,
    output logic [WIDTH-1:0] rd_a_data,
    output logic [WIDTH-1:0] rd_b_data,
    input  logic             issue,
    input  logic [AW-1:0]    issue_dst,
    input  logic             wb_en,
    input  logic [AW-1:0]    wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    output logic             stall,
    output logic [NREG-1:0]  busy
);

    logic [WIDTH-1:0] regs_q [NREG];
    logic [NREG-1:0]  busy_q, busy_d;
    logic [WIDTH-1:0] rd_a_q, rd_a_d;
    logic [WIDTH-1:0] rd_b_q, rd_b_d;
    logic             byp_a, byp_b;
    logic             haz_a, haz_b;
    logic             issue_eff;
    logic             rd_go;

    always_comb begin
        byp_a     = wb_en && (wb_addr == rd_a_addr);
        byp_b     = wb_en && (wb_addr == rd_b_addr);
        haz_a     = busy_q[rd_a_addr] && !byp_a;
        haz_b     = busy_q[rd_b_addr] && !byp_b;
        stall     = rd_en && (haz_a || haz_b);
        issue_eff = issue && !stall;
        rd_go     = rd_en && !stall;
    end

    // Issue is applied after write-back so a new producer keeps the bit set.
    always_comb begin
        busy_d = busy_q;
        if (wb_en)
            busy_d[wb_addr] = 1'b0;
        if (issue_eff)
            busy_d[issue_dst] = 1'b1;
    end

    always_comb begin
        rd_a_d = rd_a_q;
        rd_b_d = rd_b_q;
        if (rd_go) begin
            rd_a_d = byp_a ? wb_data : regs_q[rd_a_addr];
            rd_b_d = byp_b ? wb_data : regs_q[rd_b_addr];
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < NREG; i++)
                regs_q[i] <= '0;
            busy_q <= '0;
            rd_a_q <= '0;
            rd_b_q <= '0;
        end else begin
            if (wb_en)
                regs_q[wb_addr] <= wb_data;
            busy_q <= busy_d;
            rd_a_q <= rd_a_d;
            rd_b_q <= rd_b_d;
        end
    end

    assign rd_a_data = rd_a_q;
    assign rd_b_data = rd_b_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_regfile_sb16.sv
// Directed bench for regfile_sb16: read results go through a scoreboard queue.
// Stall and busy are checked against constants for each step.
module tb_regfile_sb16;

    localparam int W  = 16;
    localparam int AW = 3;
    localparam int N  = 8;

    logic          CLK = 1'b0;
    logic          RSTN;
    logic          rd_en;
    logic [AW-1:0] rd_a_addr, rd_b_addr;
    logic [W-1:0]  rd_a_data, rd_b_data;
    logic          issue;
    logic [AW-1:0] issue_dst;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [W-1:0]  wb_data;
    logic          stall;
    logic [N-1:0]  busy;

    int total  = 0;
    int passed = 0;

    logic [W-1:0]   mreg [N];
    logic [2*W-1:0] sbq [$];
    logic [W-1:0]   last_a, last_b;

    regfile_sb16 dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .rd_en     (rd_en),
        .rd_a_addr (rd_a_addr),
        .rd_b_addr (rd_b_addr),
        .rd_a_data (rd_a_data),
        .rd_b_data (rd_b_data),
        .issue     (issue),
        .issue_dst (issue_dst),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .stall     (stall),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [W-1:0] obs,
                         input logic [W-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic idle();
        rd_en = 0; rd_a_addr = 0; rd_b_addr = 0;
        issue = 0; issue_dst = 0;
        wb_en = 0; wb_addr = 0; wb_data = 0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) mreg[i] = '0;
        sbq.delete();
        last_a = '0;
        last_b = '0;
    endtask

    // One clock: check stall before the edge, results 1ns after it.
    task automatic cyc(input string tag, input logic exp_stall);
        logic [W-1:0]   ea, eb;
        logic [2*W-1:0] e;
        #1;
        check({tag, ".stall"}, {15'd0, stall}, {15'd0, exp_stall});
        if (rd_en && !exp_stall) begin
            ea = (wb_en && wb_addr == rd_a_addr) ? wb_data : mreg[rd_a_addr];
            eb = (wb_en && wb_addr == rd_b_addr) ? wb_data : mreg[rd_b_addr];
            sbq.push_back({ea, eb});
        end
        @(posedge CLK);
        #1;
        if (wb_en) mreg[wb_addr] = wb_data;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            last_a = e[2*W-1:W];
            last_b = e[W-1:0];
        end
        check({tag, ".rd_a"}, rd_a_data, last_a);
        check({tag, ".rd_b"}, rd_b_data, last_b);
        idle();
    endtask

    task automatic chk_busy(input string tag, input logic [N-1:0] exp);
        check(tag, {8'd0, busy}, {8'd0, exp});
    endtask

    initial begin
        idle();
        model_clear();
        RSTN = 0;
        repeat (2) @(posedge CLK);
        #1 RSTN = 1;
        chk_busy("rst.busy", 8'h00);
        check("rst.rd_a", rd_a_data, 16'h0);
        check("rst.rd_b", rd_b_data, 16'h0);

        // write then read, same address on both ports
        wb_en = 1; wb_addr = 3; wb_data = 16'h1234;
        cyc("wr3", 0);
        rd_en = 1; rd_a_addr = 3; rd_b_addr = 3;
        cyc("rd33", 0);
        check("rd33.a_const", rd_a_data, 16'h1234);

        // same-cycle bypass
        wb_en = 1; wb_addr = 5; wb_data = 16'h00AA;
        cyc("wr5", 0);
        wb_en = 1; wb_addr = 5; wb_data = 16'hBEEF;
        rd_en = 1; rd_a_addr = 5; rd_b_addr = 0;
        cyc("byp5", 0);
        check("byp5.a_const", rd_a_data, 16'hBEEF);

        // RAW hazard
        issue = 1; issue_dst = 2;
        cyc("iss2", 0);
        chk_busy("iss2.busy", 8'h04);
        for (int i = 0; i < 3; i++) begin
            rd_en = 1; rd_a_addr = 2; rd_b_addr = 0;
            cyc("raw2", 1);
        end
        check("raw2.hold", rd_a_data, 16'hBEEF);
        rd_en = 1; rd_a_addr = 2; rd_b_addr = 0;
        wb_en = 1; wb_addr = 2; wb_data = 16'h0042;
        cyc("raw2wb", 0);
        check("raw2wb.a_const", rd_a_data, 16'h0042);
        chk_busy("raw2wb.busy", 8'h00);

        // set-over-clear
        issue = 1; issue_dst = 6;
        wb_en = 1; wb_addr = 6; wb_data = 16'h7777;
        cyc("soc6", 0);
        chk_busy("soc6.busy", 8'h40);
        rd_en = 1; rd_a_addr = 6; rd_b_addr = 3;
        cyc("soc6rd", 1);
        wb_en = 1; wb_addr = 7; wb_data = 16'h0707;
        cyc("wr7", 0);
        chk_busy("wr7.busy", 8'h40);
        wb_en = 1; wb_addr = 6; wb_data = 16'h7777;
        cyc("clr6", 0);
        rd_en = 1; rd_a_addr = 6; rd_b_addr = 7;
        cyc("rd67", 0);
        check("rd67.a_const", rd_a_data, 16'h7777);

        // stalled issue must not set busy
        issue = 1; issue_dst = 1;
        cyc("iss1", 0);
        for (int i = 0; i < 2; i++) begin
            rd_en = 1; rd_a_addr = 1; rd_b_addr = 1;
            issue = 1; issue_dst = 4;
            cyc("stiss", 1);
            chk_busy("stiss.busy", 8'h02);
        end
        rd_en = 1; rd_a_addr = 1; rd_b_addr = 1;
        issue = 1; issue_dst = 4;
        wb_en = 1; wb_addr = 1; wb_data = 16'h0101;
        cyc("stissok", 0);
        chk_busy("stissok.busy", 8'h10);

        // self-dependency reads the pre-issue value
        rd_en = 1; rd_a_addr = 3; rd_b_addr = 7;
        issue = 1; issue_dst = 3;
        cyc("self3", 0);
        check("self3.a_const", rd_a_data, 16'h1234);
        chk_busy("self3.busy", 8'h18);

        // asynchronous reset mid-run with busy = 0F
        wb_en = 1; wb_addr = 4; wb_data = 16'h4444;
        cyc("wb4", 0);
        wb_en = 1; wb_addr = 3; wb_data = 16'h3333;
        cyc("wb3", 0);
        for (int i = 0; i < 4; i++) begin
            issue = 1; issue_dst = AW'(i);
            cyc("iss03", 0);
        end
        chk_busy("pre_rst.busy", 8'h0F);
        rd_en = 1; rd_a_addr = 5; rd_b_addr = 6;
        cyc("pre_rst.rd", 0);
        #2 RSTN = 0;
        #1;
        chk_busy("arst.busy", 8'h00);
        check("arst.rd_a", rd_a_data, 16'h0);
        check("arst.rd_b", rd_b_data, 16'h0);
        model_clear();
        @(posedge CLK);
        #1 RSTN = 1;
        for (int i = 0; i < N; i++) begin
            rd_en = 1; rd_a_addr = AW'(i); rd_b_addr = AW'(N - 1 - i);
            cyc("post_rst", 0);
            check("post_rst.a0", rd_a_data, 16'h0);
        end
        chk_busy("post_rst.busy", 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
